dm_bytelane: RTL and testbench
==============================

// Module: dm_bytelane
// PURPOSE
//   Parametrised data memory for the CPU datapath. Successor to the fixed 32x32 word memory.
//   Adds byte/halfword/word access with sign/zero extension and a clocked write.
//   Adds a registered read, alignment/range error reporting, and a post-reset hardware clear sequence.
//   Sits between the ALU address output and the writeback mux.
// PARAMETERS
//   ADDR_WIDTH  10   byte-address width; word index = addr[ADDR_WIDTH-1:2]
//   DEPTH       256  number of 32-bit words implemented (<= 2**(ADDR_WIDTH-2))
// PORTS
//   clk           in   1           clock; all state updates on rising edge
//   rst           in   1           reset, synchronous, active-high
//   addr          in   ADDR_WIDTH  byte address
//   din           in   32          store data, right-justified (byte in [7:0], half in [15:0])
//   MemWrite      in   1           store request this cycle
//   MemRead       in   1           load request this cycle
//   mem_size      in   2           00 byte, 01 half, 10 word, 11 reserved
//   mem_unsigned  in   1           1: zero-extend loads; 0: sign-extend
//   dout          out  32          load data, registered
//   rvalid        out  1           1-cycle pulse: dout holds result of load issued previous cycle
//   err           out  1           1-cycle pulse: access issued previous cycle was rejected
//   busy          out  1           1 while clear sequence runs; requests ignored
// BEHAVIOUR
//   Reset (rst=1 at edge): dout=0, rvalid=0, err=0, busy=1, clear pointer=0, FSM->CLEAR.
//   FSM CLEAR: each cycle writes 0 to word[ptr], ptr++.
//     - After writing word DEPTH-1 -> IDLE; busy=0 from the next cycle. Clear takes exactly DEPTH cycles.
//     - MemRead/MemWrite ignored in CLEAR: no write, rvalid=0, err=0.
//     - rst asserted mid-clear restarts the clear at ptr=0.
//   FSM IDLE: serves requests; stays until rst.
//   Access is rejected (err=1 next cycle, no write, rvalid=0, dout unchanged) when:
//     - mem_size=11.
//     - Half access with addr[0]=1.
//     - Word access with addr[1:0]!=00.
//     - Word index >= DEPTH.
//     - Rejection applies only when MemRead|MemWrite=1.
//   Store (accepted): at the edge, only the addressed lanes of word[addr>>2] are written.
//     - Byte: lane addr[1:0] <- din[7:0].
//     - Half: lanes {addr[1],1'b1}/{addr[1],1'b0} <- din[15:0], little-endian.
//     - Word: all lanes <- din. Other lanes unchanged.
//   Load (accepted): 1-cycle latency.
//     - At the edge, the addressed byte/half/word is extracted (little-endian).
//     - Extended to 32 bits per mem_unsigned (ignored for word), then registered into dout; rvalid=1.
//   No load accepted: dout holds its previous value; rvalid=0.
//   MemRead & MemWrite same cycle: the store is performed; the load returns pre-store (old) contents.
//   Load in the cycle after a store to the same word returns new data (no forwarding needed).
//   Memory array is not reset combinationally; contents are defined only after CLEAR completes.
// TESTING
//   1. rst 1 cycle, then idle -> busy=1 exactly DEPTH cycles.
//      A word read at index DEPTH-1 returns 0x00000000 with rvalid=1 one cycle later.
//   2. sw 0x8899AABB @0x10, then lb @0x13 -> dout=0xFFFFFF88.
//      lbu @0x13 -> 0x00000088; lh @0x10 -> 0xFFFFAABB; lhu @0x12 -> 0x00008899.
//   3. sw 0xFFFFFFFF @0x20, sb 0x12 @0x21, sh 0x3456 @0x22 -> lw @0x20 = 0x345612FF.
//   4. sh @0x01, sw @0x02, mem_size=11, and lw @ index DEPTH (when DEPTH < 2**(ADDR_WIDTH-2)):
//      - err=1 next cycle, rvalid=0, dout unchanged.
//      - Memory unchanged (verified by lw).
//   5. MemRead=MemWrite=1, sw 0xDEADBEEF @0x40 (old 0x0) -> dout=0x00000000 next cycle.
//      lw @0x40 following -> 0xDEADBEEF.
//   6. rst pulsed at clear cycle 5 -> busy stays 1 for a further DEPTH cycles.
//      Earlier stored data reads back 0.

Source files
------------

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte/half/word data memory with registered read,
// access-error reporting and a post-reset clear sequence.
//   clk, rst      : clock, synchronous active-high reset
//   addr, din     : byte address, right-justified store data
//   MemWrite/Read : store/load request this cycle
//   mem_size      : 00 byte, 01 half, 10 word, 11 reserved
//   mem_unsigned  : 1 zero-extends loads, 0 sign-extends
//   dout, rvalid  : registered load data and its 1-cycle valid pulse
//   err           : 1-cycle pulse, previous access rejected
//   busy          : high while the clear sequence runs
module dm_bytelane #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic [31:0]           dout,
  output logic                  rvalid,
  output logic                  err,
  output logic                  busy
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0]   LP_DEPTH = (IW+1)'(DEPTH);
  localparam logic [DW-1:0] LP_LAST  = DW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_ptr;
  logic [31:0]   r_mem [DEPTH];

  logic [IW-1:0] w_widx;
  logic [DW-1:0] w_mi;
  logic          w_oor;
  logic          w_bad;
  logic          w_req;
  logic          w_idle;
  logic          w_acc;
  logic [31:0]   w_rword;
  logic [31:0]   w_sh;
  logic [15:0]   w_h;
  logic [31:0]   w_ld;
  logic [3:0]    w_lane;
  logic [31:0]   w_ldat;
  logic [3:0]    w_wen;
  logic [DW-1:0] w_wi;
  logic [31:0]   w_wdat;

  assign w_widx = addr[ADDR_WIDTH-1:2];
  assign w_mi   = w_widx[DW-1:0];
  assign w_oor  = {1'b0, w_widx} >= LP_DEPTH;
  assign w_req  = MemRead | MemWrite;
  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = w_idle & w_req & ~w_bad;

  always_comb begin
    w_bad = 1'b0;
    case (mem_size)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = addr[0];
      2'b10:   w_bad = (addr[1:0] != 2'b00);
      default: w_bad = 1'b1;
    endcase
    w_bad = w_bad | w_oor;
  end

  // Read path sees pre-edge contents, so a
  // simultaneous store returns the old word.
  assign w_rword = w_oor ? 32'h0 : r_mem[w_mi];
  assign w_sh    = w_rword >> {addr[1:0], 3'b000};
  assign w_h     = addr[1] ? w_rword[31:16]
                           : w_rword[15:0];

  always_comb begin
    w_ld = w_rword;
    case (mem_size)
      2'b00:
        w_ld = {{24{~mem_unsigned & w_sh[7]}},
                w_sh[7:0]};
      2'b01:
        w_ld = {{16{~mem_unsigned & w_h[15]}},
                w_h};
      default: w_ld = w_rword;
    endcase
  end

  // Store data is replicated across lanes;
  // the lane mask picks the target bytes.
  always_comb begin
    w_lane = 4'hF;
    w_ldat = din;
    case (mem_size)
      2'b00: begin
        w_lane = 4'b0001 << addr[1:0];
        w_ldat = {4{din[7:0]}};
      end
      2'b01: begin
        w_lane = addr[1] ? 4'b1100 : 4'b0011;
        w_ldat = {2{din[15:0]}};
      end
      default: begin
        w_lane = 4'hF;
        w_ldat = din;
      end
    endcase
  end

  always_comb begin
    w_wen  = 4'h0;
    w_wi   = w_mi;
    w_wdat = w_ldat;
    if (rst) begin
      w_wen = 4'h0;
    end else if (!w_idle) begin
      w_wen  = 4'hF;
      w_wi   = r_ptr;
      w_wdat = 32'h0;
    end else if (w_acc && MemWrite) begin
      w_wen = w_lane;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wen[i])
        r_mem[w_wi][8*i +: 8] <= w_wdat[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      busy    <= 1'b1;
      dout    <= 32'h0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LP_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_req && w_bad)
            err <= 1'b1;
          if (w_acc && MemRead) begin
            dout   <= w_ld;
            rvalid <= 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed and random checks of dm_bytelane
// against a byte-array reference model.
module tb_dm_bytelane;

  localparam int AW = 10;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [31:0]   din = '0;
  logic          MemWrite = 1'b0;
  logic          MemRead = 1'b0;
  logic [1:0]    mem_size = 2'b00;
  logic          mem_unsigned = 1'b0;
  logic [31:0]   dout;
  logic          rvalid;
  logic          err;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem_b [D*4];
  logic [31:0] exp_dout;

  dm_bytelane #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .dout(dout), .rvalid(rvalid), .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_bad(int a, int sz);
    if (sz == 3) return 1;
    if (sz == 1 && (a % 2) != 0) return 1;
    if (sz == 2 && (a % 4) != 0) return 1;
    if (a / 4 >= D) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(int a, int sz,
                                         bit uns);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mem_b[a+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < D*4; i++) mem_b[i] = 8'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(string tag, bit rd, bit wr,
                       logic [1:0] sz, bit uns, int a,
                       logic [31:0] d);
    bit e_err = 0;
    bit e_rv = 0;
    MemRead = rd;
    MemWrite = wr;
    mem_size = sz;
    mem_unsigned = uns;
    addr = AW'(a);
    din = d;
    step();
    if ((rd || wr) && m_bad(a, int'(sz))) begin
      e_err = 1;
    end else if (rd || wr) begin
      if (rd) begin
        exp_dout = m_load(a, int'(sz), uns);
        e_rv = 1;
      end
      if (wr) begin
        for (int i = 0; i < (1 << sz); i++)
          mem_b[a+i] = d[8*i +: 8];
      end
    end
    MemRead = 0;
    MemWrite = 0;
    chk({tag, ".err"}, 32'(err), 32'(e_err));
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(e_rv));
    chk({tag, ".dout"}, dout, exp_dout);
  endtask

  task automatic count_busy(string tag);
    int n = 1;
    int lim = 0;
    while (busy === 1'b1 && lim < 4*D) begin
      step();
      lim++;
      if (busy === 1'b1) n++;
      chk({tag, ".clr_rvalid"}, 32'(rvalid), 32'h0);
      chk({tag, ".clr_err"}, 32'(err), 32'h0);
    end
    chk({tag, ".busy_len"}, 32'(n), 32'(D));
  endtask

  initial begin
    // reset and first clear
    rst = 1;
    step();
    chk("rst.dout", dout, 32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.busy", 32'(busy), 32'h1);
    rst = 0;
    count_busy("clr1");
    m_clear();
    exp_dout = 32'h0;
    do_op("lw_last", 1, 0, 2, 0, (D-1)*4, 0);

    // sign / zero extension
    do_op("sw10", 0, 1, 2, 0, 'h10, 32'h8899AABB);
    do_op("lb13", 1, 0, 0, 0, 'h13, 0);
    chk("lb13.val", dout, 32'hFFFFFF88);
    do_op("lbu13", 1, 0, 0, 1, 'h13, 0);
    chk("lbu13.val", dout, 32'h00000088);
    do_op("lh10", 1, 0, 1, 0, 'h10, 0);
    chk("lh10.val", dout, 32'hFFFFAABB);
    do_op("lhu12", 1, 0, 1, 1, 'h12, 0);
    chk("lhu12.val", dout, 32'h00008899);

    // partial lane stores
    do_op("sw20", 0, 1, 2, 0, 'h20, 32'hFFFFFFFF);
    do_op("sb21", 0, 1, 0, 0, 'h21, 32'hABCD0012);
    do_op("sh22", 0, 1, 1, 0, 'h22, 32'h99993456);
    do_op("lw20", 1, 0, 2, 0, 'h20, 0);
    chk("lw20.val", dout, 32'h345612FF);

    // rejected accesses leave state alone
    do_op("sh01", 0, 1, 1, 0, 'h01, 32'h1111);
    do_op("sw02", 0, 1, 2, 0, 'h02, 32'h22222222);
    do_op("sz11w", 0, 1, 3, 0, 'h10, 32'h33333333);
    do_op("sz11r", 1, 0, 3, 0, 'h10, 0);
    do_op("lw_oor", 1, 0, 2, 0, D*4, 0);
    do_op("sw_oor", 0, 1, 2, 0, D*4, 32'h44444444);
    chk("rej.dout_hold", dout, 32'h345612FF);
    do_op("lw00", 1, 0, 2, 0, 'h00, 0);
    do_op("lw10b", 1, 0, 2, 0, 'h10, 0);
    chk("lw10b.val", dout, 32'h8899AABB);

    // read-and-write in one cycle
    do_op("rw40", 1, 1, 2, 0, 'h40, 32'hDEADBEEF);
    chk("rw40.old", dout, 32'h00000000);
    do_op("lw40", 1, 0, 2, 0, 'h40, 0);
    chk("lw40.val", dout, 32'hDEADBEEF);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      do_op("rnd",
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, D*4 + 15)),
            $urandom());
    end

    // reset restarted mid-clear; requests ignored
    rst = 1;
    step();
    rst = 0;
    for (int k = 0; k < 5; k++) step();
    chk("clr2.busy5", 32'(busy), 32'h1);
    rst = 1;
    step();
    rst = 0;
    MemWrite = 1;
    MemRead = 1;
    mem_size = 2'b10;
    addr = AW'('h10);
    din = 32'hCAFEF00D;
    count_busy("clr3");
    MemWrite = 0;
    MemRead = 0;
    m_clear();
    exp_dout = 32'h0;
    do_op("post10", 1, 0, 2, 0, 'h10, 0);
    do_op("post40", 1, 0, 2, 0, 'h40, 0);
    do_op("post20", 1, 0, 2, 0, 'h20, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
